// File: rtl/rat_multi.sv
// Multi-issue register alias table: maps each architectural register to the ROB
// entry producing its next value, with intra-group rename bypass and flush recovery.
module rat_multi #(
   parameter int ROB_DEPTH = 16,
   parameter int ROB_PTR_W = $clog2(ROB_DEPTH),
   parameter int REG_NUM   = 32,
   parameter int REG_W     = $clog2(REG_NUM),
   parameter int DISP_W    = 2,
   parameter int CMT_W     = 2
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [DISP_W-1:0]                   ren_rd_wr,
   input  logic [DISP_W-1:0][REG_W-1:0]        ren_rd_addr,
   input  logic [DISP_W-1:0][ROB_PTR_W-1:0]    ren_rob_id,
   input  logic [DISP_W-1:0][REG_W-1:0]        ren_rs1_addr,
   input  logic [DISP_W-1:0][REG_W-1:0]        ren_rs2_addr,
   output logic [DISP_W-1:0]                   rs1_valid,
   output logic [DISP_W-1:0]                   rs2_valid,
   output logic [DISP_W-1:0][ROB_PTR_W-1:0]    rs1_rob_id,
   output logic [DISP_W-1:0][ROB_PTR_W-1:0]    rs2_rob_id,
   input  logic [CMT_W-1:0]                    cmt_valid,
   input  logic [CMT_W-1:0][REG_W-1:0]         cmt_rd_addr,
   input  logic [CMT_W-1:0][ROB_PTR_W-1:0]     cmt_rob_id,
   input  logic                                flush,
   output logic [$clog2(REG_NUM+1)-1:0]        pend_cnt
);

   localparam int CNT_W = $clog2(REG_NUM+1);

   logic [REG_NUM-1:0]                valid_q, valid_d;
   logic [REG_NUM-1:0][ROB_PTR_W-1:0] rob_id_q, rob_id_d;
   logic [CNT_W-1:0]                  pend_cnt_q, pend_cnt_d;

   // Lookup: table value, overridden by the youngest older slot renaming the same register
   always_comb begin
      for (int unsigned i = 0; i < DISP_W; i++) begin
         rs1_valid[i]  = valid_q[ren_rs1_addr[i]];
         rs1_rob_id[i] = rob_id_q[ren_rs1_addr[i]];
         rs2_valid[i]  = valid_q[ren_rs2_addr[i]];
         rs2_rob_id[i] = rob_id_q[ren_rs2_addr[i]];
         for (int unsigned k = 0; k < i; k++) begin
            if (ren_rd_wr[k] && ren_rd_addr[k] == ren_rs1_addr[i]) begin
               rs1_valid[i]  = 1'b0;
               rs1_rob_id[i] = ren_rob_id[k];
            end
            if (ren_rd_wr[k] && ren_rd_addr[k] == ren_rs2_addr[i]) begin
               rs2_valid[i]  = 1'b0;
               rs2_rob_id[i] = ren_rob_id[k];
            end
         end
         if (ren_rs1_addr[i] == '0) begin
            rs1_valid[i]  = 1'b1;
            rs1_rob_id[i] = '0;
         end
         if (ren_rs2_addr[i] == '0) begin
            rs2_valid[i]  = 1'b1;
            rs2_rob_id[i] = '0;
         end
      end
   end

   // Next state: commit applied first so a same-cycle rename overrides it; flush overrides both
   always_comb begin
      valid_d  = valid_q;
      rob_id_d = rob_id_q;
      if (flush) begin
         valid_d = '1;
      end else begin
         for (int unsigned r = 1; r < REG_NUM; r++) begin
            for (int unsigned j = 0; j < CMT_W; j++) begin
               if (cmt_valid[j] && cmt_rd_addr[j] == REG_W'(r) &&
                   cmt_rob_id[j] == rob_id_q[r]) begin
                  valid_d[r] = 1'b1;
               end
            end
            for (int unsigned i = 0; i < DISP_W; i++) begin
               if (ren_rd_wr[i] && ren_rd_addr[i] == REG_W'(r)) begin
                  valid_d[r]  = 1'b0;
                  rob_id_d[r] = ren_rob_id[i];
               end
            end
         end
      end
      pend_cnt_d = '0;
      for (int unsigned r = 0; r < REG_NUM; r++) begin
         pend_cnt_d = pend_cnt_d + CNT_W'(!valid_d[r]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= '1;
         rob_id_q   <= '0;
         pend_cnt_q <= '0;
      end else begin
         valid_q    <= valid_d;
         rob_id_q   <= rob_id_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_rat_multi.sv
// Table-driven bench for rat_multi: per-cycle vectors with hand-derived lookups and
// pend_cnt, routed through an expectation queue, plus reset and x0 corner sequences.
module tb_rat_multi;

   localparam int ROB_PTR_W = 4;
   localparam int REG_W     = 5;

   logic                           clk = 1'b0;
   logic                           rst;
   logic [1:0]                     ren_rd_wr;
   logic [1:0][REG_W-1:0]          ren_rd_addr;
   logic [1:0][ROB_PTR_W-1:0]      ren_rob_id;
   logic [1:0][REG_W-1:0]          ren_rs1_addr;
   logic [1:0][REG_W-1:0]          ren_rs2_addr;
   logic [1:0]                     rs1_valid;
   logic [1:0]                     rs2_valid;
   logic [1:0][ROB_PTR_W-1:0]      rs1_rob_id;
   logic [1:0][ROB_PTR_W-1:0]      rs2_rob_id;
   logic [1:0]                     cmt_valid;
   logic [1:0][REG_W-1:0]          cmt_rd_addr;
   logic [1:0][ROB_PTR_W-1:0]      cmt_rob_id;
   logic                           flush;
   logic [5:0]                     pend_cnt;

   rat_multi #(
      .ROB_DEPTH(16),
      .REG_NUM  (32),
      .DISP_W   (2),
      .CMT_W    (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ren_rd_wr   (ren_rd_wr),
      .ren_rd_addr (ren_rd_addr),
      .ren_rob_id  (ren_rob_id),
      .ren_rs1_addr(ren_rs1_addr),
      .ren_rs2_addr(ren_rs2_addr),
      .rs1_valid   (rs1_valid),
      .rs2_valid   (rs2_valid),
      .rs1_rob_id  (rs1_rob_id),
      .rs2_rob_id  (rs2_rob_id),
      .cmt_valid   (cmt_valid),
      .cmt_rd_addr (cmt_rd_addr),
      .cmt_rob_id  (cmt_rob_id),
      .flush       (flush),
      .pend_cnt    (pend_cnt)
   );

   always #5 clk = ~clk;

   // Source expectations: -1 = value ready, otherwise busy with that ROB id
   typedef struct {
      bit       fl;
      bit [1:0] w;
      int       a0, i0, a1, i1;
      int       s10, s20, s11, s21;
      bit [1:0] c;
      int       ca0, ci0, ca1, ci1;
      int       e10, e20, e11, e21;
      int       ep;
   } vec_t;

   vec_t    vecs[$];
   int      exp_q[$];
   string   name_q[$];
   int      n_cmp = 0;
   int      n_bad = 0;

   function automatic int enc(logic v, logic [ROB_PTR_W-1:0] id);
      return v ? -1 : int'(id);
   endfunction

   task automatic check(string nm, int act, int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic idle();
      flush        = 1'b0;
      ren_rd_wr    = '0;
      ren_rd_addr  = '0;
      ren_rob_id   = '0;
      ren_rs1_addr = '0;
      ren_rs2_addr = '0;
      cmt_valid    = '0;
      cmt_rd_addr  = '0;
      cmt_rob_id   = '0;
   endtask

   task automatic drive(vec_t v, int n);
      flush           = v.fl;
      ren_rd_wr       = v.w;
      ren_rd_addr[0]  = REG_W'(v.a0);
      ren_rob_id[0]   = ROB_PTR_W'(v.i0);
      ren_rd_addr[1]  = REG_W'(v.a1);
      ren_rob_id[1]   = ROB_PTR_W'(v.i1);
      ren_rs1_addr[0] = REG_W'(v.s10);
      ren_rs2_addr[0] = REG_W'(v.s20);
      ren_rs1_addr[1] = REG_W'(v.s11);
      ren_rs2_addr[1] = REG_W'(v.s21);
      cmt_valid       = v.c;
      cmt_rd_addr[0]  = REG_W'(v.ca0);
      cmt_rob_id[0]   = ROB_PTR_W'(v.ci0);
      cmt_rd_addr[1]  = REG_W'(v.ca1);
      cmt_rob_id[1]   = ROB_PTR_W'(v.ci1);
      exp_q.push_back(v.e10); name_q.push_back($sformatf("v%0d_s0_rs1", n));
      exp_q.push_back(v.e20); name_q.push_back($sformatf("v%0d_s0_rs2", n));
      exp_q.push_back(v.e11); name_q.push_back($sformatf("v%0d_s1_rs1", n));
      exp_q.push_back(v.e21); name_q.push_back($sformatf("v%0d_s1_rs2", n));
      exp_q.push_back(v.ep);  name_q.push_back($sformatf("v%0d_pend", n));
   endtask

   task automatic sample();
      int act[5];
      act[0] = enc(rs1_valid[0], rs1_rob_id[0]);
      act[1] = enc(rs2_valid[0], rs2_rob_id[0]);
      act[2] = enc(rs1_valid[1], rs1_rob_id[1]);
      act[3] = enc(rs2_valid[1], rs2_rob_id[1]);
      act[4] = int'(pend_cnt);
      for (int k = 0; k < 5; k++) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
         end else begin
            check(name_q.pop_front(), act[k], exp_q.pop_front());
         end
      end
   endtask

   initial begin
      //            fl  w      a0 i0 a1 i1  s10 s20 s11 s21  c     ca0 ci0 ca1 ci1  e10 e20 e11 e21 ep
      vecs.push_back('{0, 2'b00,  0, 0, 0, 0,   5,  0,  5, 31, 2'b00,  0,  0,  0, 0,  -1, -1, -1, -1, 0});
      vecs.push_back('{0, 2'b01,  5, 3, 0, 0,   5,  5,  5,  6, 2'b00,  0,  0,  0, 0,  -1, -1,  3, -1, 0});
      vecs.push_back('{0, 2'b10,  0, 0, 6, 7,   5,  1,  5,  6, 2'b01,  5,  3,  0, 0,   3, -1,  3, -1, 1});
      vecs.push_back('{0, 2'b00,  0, 0, 0, 0,   5,  6,  6,  5, 2'b10,  0,  0,  6, 7,  -1,  7,  7, -1, 1});
      vecs.push_back('{0, 2'b11,  7, 4, 7, 5,   7,  0,  7,  7, 2'b00,  0,  0,  0, 0,  -1, -1,  4,  4, 0});
      vecs.push_back('{0, 2'b01,  9, 2, 0, 0,   7,  9,  9,  7, 2'b00,  0,  0,  0, 0,   5, -1,  2,  5, 1});
      vecs.push_back('{0, 2'b10,  0, 0, 9, 6,   9,  7,  9,  0, 2'b11,  9,  2,  7, 4,   2,  5,  2, -1, 2});
      vecs.push_back('{0, 2'b00,  0, 0, 0, 0,   9,  7,  9,  3, 2'b01,  9,  2,  0, 0,   6,  5,  6, -1, 2});
      vecs.push_back('{0, 2'b00,  0, 0, 0, 0,   9,  7,  9,  7, 2'b10,  0,  0,  9, 6,   6,  5,  6,  5, 2});
      vecs.push_back('{0, 2'b11,  3,10, 4,11,   9,  7,  3,  4, 2'b01,  7,  5,  0, 0,  -1,  5, 10, -1, 1});
      vecs.push_back('{1, 2'b01,  8,12, 0, 0,   3,  4,  8,  7, 2'b01,  3, 10,  0, 0,  10, 11, 12, -1, 2});
      vecs.push_back('{0, 2'b11,  0, 1, 0, 1,   3,  8,  0,  8, 2'b00,  0,  0,  0, 0,  -1, -1, -1, -1, 0});
      vecs.push_back('{0, 2'b00,  0, 0, 0, 0,   0,  3,  0,  4, 2'b01,  3, 10,  0, 0,  -1, -1, -1, -1, 0});
      vecs.push_back('{0, 2'b01, 12,15, 0, 0,  12,  0, 12,  0, 2'b00,  0,  0,  0, 0,  -1, -1, 15, -1, 0});
      vecs.push_back('{0, 2'b10,  0, 0,13, 0,  12, 13, 13, 12, 2'b01, 12, 15,  0, 0,  15, -1, -1, 15, 1});
      vecs.push_back('{0, 2'b00,  0, 0, 0, 0,  13, 12, 13,  0, 2'b10,  0,  0, 13, 0,   0, -1,  0, -1, 1});
      vecs.push_back('{0, 2'b00,  0, 0, 0, 0,  13, 12,  0,  0, 2'b00,  0,  0,  0, 0,  -1, -1, -1, -1, 0});

      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      foreach (vecs[n]) begin
         drive(vecs[n], n);
         @(negedge clk);
         sample();
         @(posedge clk);
         #1;
      end
      idle();

      // x0 rename attempted on both slots: lookups of x0 stay ready with id 0
      ren_rd_wr      = 2'b11;
      ren_rd_addr[0] = '0;
      ren_rob_id[0]  = 4'd9;
      ren_rd_addr[1] = '0;
      ren_rob_id[1]  = 4'd10;
      ren_rs1_addr[1] = '0;
      ren_rs2_addr[1] = '0;
      @(negedge clk);
      check("x0_valid", int'(rs1_valid[1]), 1);
      check("x0_rob_id", int'(rs1_rob_id[1]), 0);
      @(posedge clk);
      #1 idle();
      check("x0_pend", int'(pend_cnt), 0);

      // Make x21 busy, then reset in the same cycle as a rename of x20 and a flush
      ren_rd_wr      = 2'b01;
      ren_rd_addr[0] = REG_W'(21);
      ren_rob_id[0]  = 4'd4;
      @(posedge clk);
      #1 idle();
      check("pre_rst_pend", int'(pend_cnt), 1);
      rst            = 1'b1;
      flush          = 1'b1;
      ren_rd_wr      = 2'b01;
      ren_rd_addr[0] = REG_W'(20);
      ren_rob_id[0]  = 4'd5;
      @(posedge clk);
      #1 idle();
      rst = 1'b0;
      ren_rs1_addr[0] = REG_W'(21);
      ren_rs2_addr[0] = REG_W'(20);
      @(negedge clk);
      check("rst_pend", int'(pend_cnt), 0);
      check("rst_x21", enc(rs1_valid[0], rs1_rob_id[0]), -1);
      check("rst_x21_id", int'(rs1_rob_id[0]), 0);
      check("rst_x20", enc(rs2_valid[0], rs2_rob_id[0]), -1);
      check("sb_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
